lut_frac_chain: RTL and testbench

// Fracturable LUT with an on-block serial configuration chain, load counter and optional
// per-output registers. Either one (INPUTS+1)-input LUT or two independent INPUTS-input LUTs.

---
 rtl/lut_frac_chain_if.sv | 23 ++
 rtl/lut_frac_chain.sv | 78 +++++++
 tb/tb_lut_frac_chain.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lut_frac_chain_if.sv
// Bus between the CLB input crossbar / config chain and the fracturable LUT.
// master drives address, enables and serial config; slave returns outputs and chain status.
interface lut_frac_chain_if #(
    parameter int INPUTS = 4
);
    logic [2*INPUTS-1:0] addr;
    logic                ce;
    logic [1:0]          out;
    logic                cen;
    logic                config_in;
    logic                config_out;
    logic                cfg_done;

    modport master (
        output addr, ce, cen, config_in,
        input  out, config_out, cfg_done
    );

    modport slave (
        input  addr, ce, cen, config_in,
        output out, config_out, cfg_done
    );
endinterface

// File: rtl/lut_frac_chain.sv
// Fracturable LUT: one (INPUTS+1)-input LUT or two INPUTS-input LUTs, configured through a
// serial daisy chain with a load counter and optional per-output registers.
module lut_frac_chain #(
    parameter int INPUTS = 4
) (
    input logic              clk,
    input logic              rst_n,
    lut_frac_chain_if.slave  bus
);
    localparam int MEM_SIZE = 2**INPUTS;
    localparam int CFG_BITS = 2*MEM_SIZE + 3;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0]   cfg_p0;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  cen_q;
    logic [1:0]            q_p1;

    logic                  split;
    logic [1:0]            reg_en;
    logic [2*MEM_SIZE-1:0] mem;
    logic [MEM_SIZE-1:0]   lo;
    logic [MEM_SIZE-1:0]   hi;
    logic [INPUTS:0]       idx;
    logic [1:0]            lut_c;

    assign split  = cfg_p0[CFG_BITS-1];
    assign reg_en = cfg_p0[CFG_BITS-2 -: 2];
    assign mem    = cfg_p0[2*MEM_SIZE-1:0];
    assign lo     = mem[MEM_SIZE-1:0];
    assign hi     = mem[2*MEM_SIZE-1 -: MEM_SIZE];
    assign idx    = {bus.addr[INPUTS], bus.addr[INPUTS-1:0]};

    // Stage p0: config shift register and load counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_p0  <= '0;
            bit_cnt <= '0;
            cen_q   <= 1'b0;
        end else begin
            cen_q <= bus.cen;
            if (bus.cen) begin
                cfg_p0 <= {cfg_p0[CFG_BITS-2:0], bus.config_in};
                // Counter saturates so a long pass-through shift still reports a full load.
                if (!cen_q)
                    bit_cnt <= CNT_W'(1);
                else if (bit_cnt != CNT_MAX)
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.config_out = cfg_p0[CFG_BITS-1];
    assign bus.cfg_done   = (bit_cnt == CNT_MAX) & ~bus.cen;

    always_comb begin
        lut_c = {2{mem[idx]}};
        if (split) begin
            lut_c[0] = lo[bus.addr[INPUTS-1:0]];
            lut_c[1] = hi[bus.addr[2*INPUTS-1:INPUTS]];
        end
    end

    // Stage p1: optional output registers; shifting has priority over the user enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1 <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (reg_en[i] && bus.ce && !bus.cen)
                    q_p1[i] <= lut_c[i];
            end
        end
    end

    assign bus.out = (reg_en & q_p1) | (~reg_en & lut_c & {2{~bus.cen}});
endmodule

// File: tb/tb_lut_frac_chain.sv
// Directed bench for lut_frac_chain with INPUTS=2 (MEM_SIZE=4, CFG_BITS=11).
module tb_lut_frac_chain;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    lut_frac_chain_if #(.INPUTS(2)) bus ();

    lut_frac_chain #(.INPUTS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        logic [3:0] addr;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.cen       = 1'b1;
            bus.config_in = bits[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_load(input string nm);
        bus.cen = 1'b0;
        #1;
        chk(nm, 32'(bus.cfg_done), 32'd1);
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[k]) begin
            if (vecs[k].phase == p) begin
                bus.addr = vecs[k].addr;
                #1;
                chk($sformatf("lut p%0d addr=%b", p, vecs[k].addr), 32'(bus.out), 32'(vecs[k].exp));
            end
        end
    endtask

    localparam logic [10:0] CFG_SPLIT  = 11'b1_00_1000_0000;
    localparam logic [10:0] CFG_WIDE   = 11'b0_00_1000_0000;
    localparam logic [10:0] CFG_REG    = 11'b1_01_1000_0110;
    localparam logic [10:0] CFG_FILLER = 11'b101_1001_1010;

    initial begin
        logic [21:0] seq;
        n_checks = 0;
        n_pass   = 0;

        // phase 1: split, hi=1000 lo=0000; phase 2: single 3-input LUT, mem=1000_0000
        vecs[0]  = '{1, 4'b1101, 2'b10};
        vecs[1]  = '{1, 4'b0111, 2'b00};
        vecs[2]  = '{1, 4'b1100, 2'b10};
        vecs[3]  = '{1, 4'b0011, 2'b00};
        vecs[4]  = '{1, 4'b1000, 2'b00};
        vecs[5]  = '{1, 4'b0000, 2'b00};
        vecs[6]  = '{2, 4'b0111, 2'b11};
        vecs[7]  = '{2, 4'b1111, 2'b11};
        vecs[8]  = '{2, 4'b0110, 2'b00};
        vecs[9]  = '{2, 4'b1110, 2'b00};
        vecs[10] = '{2, 4'b0011, 2'b00};
        vecs[11] = '{2, 4'b1011, 2'b00};

        rst_n = 1'b0;
        bus.addr = 4'hF;
        bus.ce = 1'b0;
        bus.cen = 1'b0;
        bus.config_in = 1'b1;
        #12;
        chk("rst out", 32'(bus.out), 32'd0);
        chk("rst config_out", 32'(bus.config_out), 32'd0);
        chk("rst cfg_done", 32'(bus.cfg_done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst out", 32'(bus.out), 32'd0);
        chk("post-rst cfg_done", 32'(bus.cfg_done), 32'd0);

        // Split configuration
        shift_bits(32'(CFG_SPLIT), 11);
        end_load("split cfg_done");
        chk("split config_out", 32'(bus.config_out), 32'd1);
        run_phase(1);

        // Single wide LUT; addr[3] ignored
        @(posedge clk);
        #1;
        shift_bits(32'(CFG_WIDE), 11);
        end_load("wide cfg_done");
        chk("wide config_out", 32'(bus.config_out), 32'd0);
        run_phase(2);

        // Output forced low and cfg_done dropped as soon as cen rises
        @(posedge clk);
        #1;
        bus.addr = 4'b0111;
        #1;
        chk("pre-cen out", 32'(bus.out), 32'd3);
        bus.cen = 1'b1;
        #1;
        chk("cen forces out", 32'(bus.out), 32'd0);
        chk("cen drops cfg_done", 32'(bus.cfg_done), 32'd0);
        bus.cen = 1'b0;
        #1;

        // Registered low output, combinational high output
        @(posedge clk);
        #1;
        shift_bits(32'(CFG_REG), 11);
        end_load("reg cfg_done");
        bus.addr = 4'b0000;
        bus.ce = 1'b0;
        #1;
        chk("reg init", 32'(bus.out), 32'd0);
        bus.addr = 4'b0001;
        bus.ce = 1'b1;
        #1;
        chk("reg before edge", 32'(bus.out), 32'd0);
        @(posedge clk);
        #1;
        chk("reg after edge", 32'(bus.out), 32'd1);
        bus.ce = 1'b0;
        bus.addr = 4'b0000;
        @(posedge clk);
        #1;
        chk("reg hold ce=0", 32'(bus.out), 32'd1);
        bus.addr = 4'b1100;
        #1;
        chk("hi comb", 32'(bus.out), 32'd3);
        bus.addr = 4'b0000;
        bus.ce = 1'b1;
        bus.cen = 1'b1;
        bus.config_in = 1'b0;
        @(posedge clk);
        #1;
        chk("cen beats ce", 32'(bus.out), 32'd1);
        bus.ce = 1'b0;
        bus.cen = 1'b0;

        // 22-bit pass-through: config_out replays the first 11 bits
        @(posedge clk);
        #1;
        seq = {CFG_FILLER, CFG_SPLIT};
        for (int k = 1; k <= 22; k++) begin
            bus.cen = 1'b1;
            bus.config_in = seq[22 - k];
            @(posedge clk);
            #1;
            if (k >= 11 && k <= 21)
                chk($sformatf("passthru k=%0d", k), 32'(bus.config_out), 32'(CFG_FILLER[10 - (k - 11)]));
        end
        chk("passthru cfg_done while cen", 32'(bus.cfg_done), 32'd0);
        end_load("passthru cfg_done");
        run_phase(1);

        // Incomplete load, then reset mid-config and a fresh reload
        @(posedge clk);
        #1;
        shift_bits(32'(5'b10110), 5);
        bus.cen = 1'b0;
        #1;
        chk("partial cfg_done", 32'(bus.cfg_done), 32'd0);
        rst_n = 1'b0;
        bus.addr = 4'b1101;
        #1;
        chk("midrst out", 32'(bus.out), 32'd0);
        chk("midrst config_out", 32'(bus.config_out), 32'd0);
        chk("midrst cfg_done", 32'(bus.cfg_done), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("after midrst out", 32'(bus.out), 32'd0);
        @(posedge clk);
        #1;
        shift_bits(32'(CFG_SPLIT), 11);
        end_load("reload cfg_done");
        run_phase(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
